// File: rtl/se_pkg.sv
// se_pkg: shared FSM encoding and frame-length rules for the transmit framer.
package se_pkg;

   typedef enum logic [2:0] {IDLE, BODY, PAD, ABORT, DRAIN, GAP} se_state_t;

   localparam int SE_MIN_LEGAL = 3;

   function automatic logic se_len_ok(input int n, input int min_w, input int max_w);
      return n >= SE_MIN_LEGAL && n >= min_w && n <= max_w;
   endfunction

endpackage

// File: rtl/se_frame_tx.sv
// se_frame_tx: turns a valid/ready/last word stream into sop/eop/valid frames that are
// always legal for the link engine (min/max length, no adjacent sop/eop, stall and link-drop close).
module se_frame_tx
   import se_pkg::*;
#(
   parameter int DW = 64,
   parameter int MIN_WORDS = 3,
   parameter int MAX_WORDS = 528,
   parameter int IFG = 2,
   parameter int STALL_MAX = 1024,
   parameter logic [DW-1:0] PAD_WORD = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          active,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          in_ready,
   output logic          out_valid,
   output logic          out_sop,
   output logic          out_eop,
   output logic [DW-1:0] out_data,
   output logic          out_err,
   output logic          stat_pad,
   output logic          stat_trunc,
   output logic          stat_abort
);

   localparam int CW = $clog2(MAX_WORDS + 1);
   localparam int GW = $clog2(IFG + 1);
   localparam int SW = $clog2(STALL_MAX + 1);

   se_state_t     state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] n;
   logic [GW-1:0] gap;
   logic [SW-1:0] stall;
   logic          last_seen;
   logic          acc;

   assign in_ready = (state == IDLE || state == BODY) ? active : state == DRAIN;
   assign acc = in_valid & in_ready;
   assign n = (cnt == CW'(MAX_WORDS)) ? cnt : cnt + 1'b1;

   always_ff @(posedge clk) begin
      out_valid <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_err <= 1'b0;
      out_data <= '0;
      stat_pad <= 1'b0;
      stat_trunc <= 1'b0;
      stat_abort <= 1'b0;
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         gap <= '0;
         stall <= '0;
         last_seen <= 1'b0;
      end else begin
         case (state)
            IDLE: if (acc) begin
               out_valid <= 1'b1;
               out_sop <= 1'b1;
               out_data <= in_data;
               cnt <= CW'(1);
               stall <= '0;
               state <= in_last ? PAD : BODY;
            end
            BODY: if (!active) begin
               last_seen <= 1'b0;
               state <= ABORT;
            end else if (acc) begin
               out_valid <= 1'b1;
               out_data <= in_data;
               cnt <= n;
               stall <= '0;
               if (in_last && n >= CW'(MIN_WORDS)) begin
                  out_eop <= 1'b1;
                  state <= GAP;
               end else if (in_last) begin
                  state <= PAD;
               end else if (n == CW'(MAX_WORDS)) begin
                  out_eop <= 1'b1;
                  out_err <= 1'b1;
                  stat_trunc <= 1'b1;
                  state <= DRAIN;
               end
            end else if (stall == SW'(STALL_MAX)) begin
               last_seen <= 1'b0;
               state <= ABORT;
            end else begin
               stall <= stall + 1'b1;
            end
            // in_last is already consumed here, so an abort must not drain afterwards
            PAD: if (!active) begin
               last_seen <= 1'b1;
               state <= ABORT;
            end else begin
               out_valid <= 1'b1;
               out_data <= PAD_WORD;
               cnt <= n;
               if (n >= CW'(MIN_WORDS)) begin
                  out_eop <= 1'b1;
                  stat_pad <= 1'b1;
                  state <= GAP;
               end
            end
            ABORT: begin
               out_valid <= 1'b1;
               out_data <= PAD_WORD;
               cnt <= n;
               if (n >= CW'(SE_MIN_LEGAL)) begin
                  out_eop <= 1'b1;
                  out_err <= 1'b1;
                  stat_abort <= 1'b1;
                  state <= last_seen ? GAP : DRAIN;
               end
            end
            DRAIN: if (acc && in_last) state <= GAP;
            GAP: begin
               cnt <= '0;
               stall <= '0;
               gap <= (gap == GW'(IFG - 1)) ? '0 : gap + 1'b1;
               if (gap == GW'(IFG - 1)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_se_frame_tx.sv
// tb_se_frame_tx: randomized bench comparing se_frame_tx output words against a frame-level model.
module tb_se_frame_tx;
   import se_pkg::*;

   localparam int DW = 64;
   localparam int MIN_W = 3;
   localparam int MAX_W = 528;
   localparam int IFG = 2;
   localparam int STALL_MAX = 1024;
   localparam logic [DW-1:0] PAD = 64'hDEAD_BEEF_0BAD_F00D;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic active = 1'b0;
   logic in_valid = 1'b0;
   logic in_last = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic in_ready, out_valid, out_sop, out_eop, out_err, stat_pad, stat_trunc, stat_abort;
   logic [DW-1:0] out_data;

   typedef struct packed {logic [DW-1:0] d; logic s; logic e; logic r;} w_t;

   w_t got[$];
   int got_cyc[$];
   w_t exp_q[$];
   logic [DW-1:0] sent[$];
   int acc_cyc[$];
   w_t mw;
   int cyc = 0;
   int n_pad = 0, n_trunc = 0, n_abort = 0;
   int pass = 0, total = 0;

   se_frame_tx #(.DW(DW), .MIN_WORDS(MIN_W), .MAX_WORDS(MAX_W), .IFG(IFG),
                 .STALL_MAX(STALL_MAX), .PAD_WORD(PAD)) dut (
      .clk(clk), .rst(rst), .active(active), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_sop(out_sop),
      .out_eop(out_eop), .out_data(out_data), .out_err(out_err), .stat_pad(stat_pad),
      .stat_trunc(stat_trunc), .stat_abort(stat_abort));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid) begin
         mw = {out_data, out_sop, out_eop, out_err};
         got.push_back(mw);
         got_cyc.push_back(cyc);
      end
      n_pad += int'(stat_pad);
      n_trunc += int'(stat_trunc);
      n_abort += int'(stat_abort);
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear();
      got.delete(); got_cyc.delete(); exp_q.delete(); sent.delete(); acc_cyc.delete();
      n_pad = 0; n_trunc = 0; n_abort = 0;
   endtask

   task automatic put_word(input logic [DW-1:0] d, input logic l, input int bub);
      int t;
      bit done;
      in_valid = 1'b0;
      repeat (bub) begin @(posedge clk); #1; end
      in_valid = 1'b1; in_data = d; in_last = l;
      t = 0; done = 0;
      while (!done && t < 4000) begin
         @(negedge clk);
         if (in_ready) begin acc_cyc.push_back(cyc); sent.push_back(d); done = 1; end
         @(posedge clk); #1;
         t++;
      end
      if (!done) begin
         total++;
         $display("FAIL put_word_timeout waited %0d cycles, required an accept", t);
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_frame(input int len, input int maxbub);
      for (int i = 0; i < len; i++)
         put_word({$urandom, $urandom}, i == len - 1, maxbub > 0 ? $urandom_range(0, maxbub) : 0);
   endtask

   // expected output of one upstream frame (len words at sent[base]), from the framing rules
   task automatic model(input int base, input int len, input bit aborted);
      int m;
      w_t w;
      if (aborted) m = (len + 1 > SE_MIN_LEGAL) ? len + 1 : SE_MIN_LEGAL;
      else m = len > MAX_W ? MAX_W : (len < MIN_W ? MIN_W : len);
      for (int i = 0; i < m; i++) begin
         w = {i < len ? sent[base+i] : PAD, i == 0, i == m - 1, i == m - 1 && (aborted || len > MAX_W)};
         exp_q.push_back(w);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; active = 1'b0;
      idle(3);
      @(negedge clk);
      total++;
      if ({out_valid, out_sop, out_eop, out_err, stat_pad, stat_trunc, stat_abort} !== 7'b0 || out_data !== '0)
         $display("FAIL reset_outputs got v%b s%b e%b r%b d%h, required all 0", out_valid, out_sop, out_eop, out_err, out_data);
      else pass++;
      total++;
      if (in_ready !== 1'b0) $display("FAIL reset_ready got %b, required 0", in_ready); else pass++;
      @(posedge clk); #1;
      rst = 1'b0; active = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) $display("FAIL idle_ready got %b, required 1", in_ready); else pass++;
      idle(1);
   endtask

   task automatic test_single();
      clear();
      send_frame(1, 0);
      send_frame(4, 0);
      idle(20);
      model(0, 1, 0);
      model(1, 4, 0);
      total++;
      if (got.size() !== exp_q.size()) $display("FAIL single_count got %0d, required %0d", got.size(), exp_q.size()); else pass++;
      foreach (exp_q[i]) if (i < got.size()) begin
         total++;
         if (got[i] !== exp_q[i]) $display("FAIL single_word[%0d] got %h, required %h", i, got[i], exp_q[i]); else pass++;
      end
      total++;
      if (n_pad !== 1) $display("FAIL single_stat_pad got %0d, required 1", n_pad); else pass++;
      if (got.size() >= 4) begin
         total++;
         if (got_cyc[1] - got_cyc[0] !== 1 || got_cyc[2] - got_cyc[1] !== 1)
            $display("FAIL single_pad_back_to_back got gaps %0d/%0d, required 1/1", got_cyc[1] - got_cyc[0], got_cyc[2] - got_cyc[1]);
         else pass++;
         total++;
         if (got_cyc[3] - got_cyc[2] !== IFG + 1)
            $display("FAIL single_ifg got %0d, required %0d", got_cyc[3] - got_cyc[2], IFG + 1);
         else pass++;
      end
   endtask

   task automatic test_ten();
      clear();
      send_frame(10, 0);
      idle(10);
      model(0, 10, 0);
      total++;
      if (got.size() !== exp_q.size()) $display("FAIL ten_count got %0d, required %0d", got.size(), exp_q.size()); else pass++;
      foreach (exp_q[i]) if (i < got.size()) begin
         total++;
         if (got[i] !== exp_q[i]) $display("FAIL ten_word[%0d] got %h, required %h", i, got[i], exp_q[i]); else pass++;
         total++;
         if (got_cyc[i] !== acc_cyc[i] + 1) $display("FAIL ten_latency[%0d] got %0d, required 1", i, got_cyc[i] - acc_cyc[i]); else pass++;
      end
   endtask

   task automatic test_random();
      int base, len, pads, flen;
      bit inf;
      clear();
      base = 0; pads = 0;
      for (int f = 0; f < 8; f++) begin
         len = $urandom_range(1, 40);
         send_frame(len, 3);
         model(base, len, 0);
         base += len;
         if (len < MIN_W) pads++;
      end
      idle(10);
      total++;
      if (got.size() !== exp_q.size()) $display("FAIL random_count got %0d, required %0d", got.size(), exp_q.size()); else pass++;
      foreach (exp_q[i]) if (i < got.size()) begin
         total++;
         if (got[i] !== exp_q[i]) $display("FAIL random_word[%0d] got %h, required %h", i, got[i], exp_q[i]); else pass++;
      end
      total++;
      if (n_pad !== pads) $display("FAIL random_stat_pad got %0d, required %0d", n_pad, pads); else pass++;
      flen = 0; inf = 0;
      foreach (got[i]) begin
         if (got[i].s) begin
            total++;
            if (inf) $display("FAIL random_double_sop at word %0d got sop inside frame, required none", i); else pass++;
            inf = 1; flen = 0;
         end
         flen++;
         if (got[i].e) begin
            total++;
            if (!se_len_ok(flen, MIN_W, MAX_W)) $display("FAIL random_frame_len got %0d, required legal", flen); else pass++;
            inf = 0;
         end
      end
   endtask

   task automatic test_trunc();
      clear();
      send_frame(600, 0);
      send_frame(5, 0);
      idle(20);
      model(0, 600, 0);
      model(600, 5, 0);
      total++;
      if (got.size() !== exp_q.size()) $display("FAIL trunc_count got %0d, required %0d", got.size(), exp_q.size()); else pass++;
      foreach (exp_q[i]) if (i < got.size()) begin
         total++;
         if (got[i] !== exp_q[i]) $display("FAIL trunc_word[%0d] got %h, required %h", i, got[i], exp_q[i]); else pass++;
      end
      total++;
      if (n_trunc !== 1) $display("FAIL trunc_stat got %0d, required 1", n_trunc); else pass++;
      total++;
      if (sent.size() !== 605) $display("FAIL trunc_drained got %0d accepted, required 605", sent.size()); else pass++;
      if (got.size() > MAX_W) begin
         total++;
         if (got_cyc[MAX_W] - got_cyc[MAX_W-1] < IFG + 1)
            $display("FAIL trunc_ifg got %0d, required >= %0d", got_cyc[MAX_W] - got_cyc[MAX_W-1], IFG + 1);
         else pass++;
      end
   endtask

   task automatic test_drop();
      int rdy;
      clear();
      active = 1'b1;
      put_word({$urandom, $urandom}, 1'b0, 0);
      active = 1'b0;
      for (int i = 1; i < 5; i++) put_word({$urandom, $urandom}, i == 4, 0);
      in_valid = 1'b1; in_data = {$urandom, $urandom}; in_last = 1'b0;
      rdy = 0;
      repeat (30) begin @(negedge clk); if (in_ready) rdy++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if (rdy !== 0) $display("FAIL drop_ready_inactive got %0d ready cycles, required 0", rdy); else pass++;
      total++;
      if (got.size() !== 3) $display("FAIL drop_no_sop_inactive got %0d words, required 3", got.size()); else pass++;
      total++;
      if (n_abort !== 1) $display("FAIL drop_stat_abort got %0d, required 1", n_abort); else pass++;
      active = 1'b1;
      send_frame(3, 0);
      idle(10);
      model(0, 1, 1);
      model(5, 3, 0);
      total++;
      if (got.size() !== exp_q.size()) $display("FAIL drop_count got %0d, required %0d", got.size(), exp_q.size()); else pass++;
      foreach (exp_q[i]) if (i < got.size()) begin
         total++;
         if (got[i] !== exp_q[i]) $display("FAIL drop_word[%0d] got %h, required %h", i, got[i], exp_q[i]); else pass++;
      end
   endtask

   task automatic test_stall();
      clear();
      for (int i = 0; i < 3; i++) put_word({$urandom, $urandom}, 1'b0, 0);
      idle(STALL_MAX + 20);
      for (int i = 0; i < 2; i++) put_word({$urandom, $urandom}, i == 1, 0);
      send_frame(4, 0);
      idle(10);
      model(0, 3, 1);
      model(5, 4, 0);
      total++;
      if (got.size() !== exp_q.size()) $display("FAIL stall_count got %0d, required %0d", got.size(), exp_q.size()); else pass++;
      foreach (exp_q[i]) if (i < got.size()) begin
         total++;
         if (got[i] !== exp_q[i]) $display("FAIL stall_word[%0d] got %h, required %h", i, got[i], exp_q[i]); else pass++;
      end
      total++;
      if (n_abort !== 1) $display("FAIL stall_stat_abort got %0d, required 1", n_abort); else pass++;
      if (got.size() >= 4) begin
         total++;
         if (got_cyc[3] - got_cyc[2] < STALL_MAX + 1 || got_cyc[3] - got_cyc[2] > STALL_MAX + 3)
            $display("FAIL stall_timing got %0d, required %0d..%0d", got_cyc[3] - got_cyc[2], STALL_MAX + 1, STALL_MAX + 3);
         else pass++;
      end
   endtask

   task automatic test_rst_mid();
      w_t w;
      clear();
      for (int i = 0; i < 5; i++) put_word({$urandom, $urandom}, 1'b0, 0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({out_valid, out_sop, out_eop, out_err, stat_pad, stat_trunc, stat_abort} !== 7'b0 || out_data !== '0)
         $display("FAIL rst_mid_outputs got v%b s%b e%b r%b d%h, required all 0", out_valid, out_sop, out_eop, out_err, out_data);
      else pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);
      send_frame(4, 0);
      idle(10);
      for (int i = 0; i < 5; i++) begin
         w = {sent[i], i == 0, 1'b0, 1'b0};
         exp_q.push_back(w);
      end
      model(5, 4, 0);
      total++;
      if (got.size() !== exp_q.size()) $display("FAIL rst_mid_count got %0d, required %0d", got.size(), exp_q.size()); else pass++;
      foreach (exp_q[i]) if (i < got.size()) begin
         total++;
         if (got[i] !== exp_q[i]) $display("FAIL rst_mid_word[%0d] got %h, required %h", i, got[i], exp_q[i]); else pass++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_ten();
      test_random();
      test_trunc();
      test_drop();
      test_stall();
      test_rst_mid();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
